// File: rtl/ysyx_22050550_rf_pkg.sv
// Purpose: shared constants, types and the writeback-match helper for the register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_22050550_rf_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned NREG_DEF = 32;

    // wb_match works on vectors padded to these maxima so that one function
    // serves every parameterisation; callers zero-fill the unused upper part.
    localparam int unsigned MAX_NW = 8;
    localparam int unsigned MAX_AW = 8;
    localparam int unsigned PW     = $clog2(MAX_NW);

    localparam logic [MAX_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic          hit;
        logic [PW-1:0] port;
    } wb_match_t;

    function automatic int unsigned addr_width(input int unsigned nreg);
        return $clog2(nreg);
    endfunction

    // Finds the highest-index enabled writeback port targeting addr.
    // x0 never matches, so writes to it are invisible to every consumer.
    function automatic wb_match_t wb_match(
        input logic [MAX_AW-1:0]        addr,
        input logic [MAX_NW-1:0]        en,
        input logic [MAX_NW*MAX_AW-1:0] waddr
    );
        wb_match_t m;
        m = '0;
        if (addr != ZERO_REG) begin
            for (int w = 0; w < int'(MAX_NW); w++) begin
                if (en[w] && (waddr[w*MAX_AW +: MAX_AW] == addr)) begin
                    m.hit  = 1'b1;
                    m.port = PW'(w);
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22050550_rf_scoreboard.sv
// Purpose: per-register busy bits; issue sets, writeback clears, set wins on a tie.
// Latency: updates visible one cycle after the edge that samples set/clear.
// Backpressure: none; the caller qualifies set_i with its own handshake.
// Ports: clk, rst (sync, active-high); set_i/set_rd_i issue fire and target;
//        clr_en_i/clr_addr_i per-writeback-port clears; busy_o registered busy vector.
module ysyx_22050550_rf_scoreboard
    import ysyx_22050550_rf_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NW   = 2,
    parameter int unsigned AW   = addr_width(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [AW-1:0]    set_rd_i,
    input  logic [NW-1:0]    clr_en_i,
    input  logic [NW*AW-1:0] clr_addr_i,
    output logic [NREG-1:0]  busy_o
);

    logic [NREG-1:0]          busy_q;
    logic [NREG-1:0]          busy_d;
    logic [MAX_NW-1:0]        en_pad;
    logic [MAX_NW*MAX_AW-1:0] addr_pad;

    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        for (int w = 0; w < int'(NW); w++) begin
            en_pad[w]                   = clr_en_i[w];
            addr_pad[w*MAX_AW +: AW]    = clr_addr_i[w*AW +: AW];
        end
    end

    always_comb begin
        wb_match_t m;
        busy_d = busy_q;
        for (int r = 1; r < int'(NREG); r++) begin
            m = wb_match(MAX_AW'(r), en_pad, addr_pad);
            // Padded enables are zero above NW, so a hit always names a real port.
            if (m.hit && (int'(m.port) < int'(NW))) begin
                busy_d[r] = 1'b0;
            end
        end
        // Applied after the clears: a new producer takes ownership of the register.
        if (set_i && (set_rd_i != '0)) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ysyx_22050550_regfile_sb.sv
// Purpose: NR-read / NW-writeback integer register file with busy scoreboard; x0 reads 0.
// Latency: reads combinational; writes and issue allocations visible the next cycle.
// Backpressure: iss_ready_o drops while iss_rd_i is busy (WAW stall) or during reset.
// Ports: clk, rst (sync, active-high); rd_addr_i/rd_data_o/rd_busy_o read ports;
//        wb_en_i/wb_addr_i/wb_data_i writeback ports; iss_valid_i/iss_rd_i/iss_ready_o issue.
// Config: define YSYX_22050550_RF_BYPASS_EN for same-cycle writeback-to-read forwarding.
module ysyx_22050550_regfile_sb
    import ysyx_22050550_rf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NR   = 2,
    parameter int unsigned NW   = 2,
    parameter int unsigned AW   = addr_width(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR*AW-1:0]   rd_addr_i,
    output logic [NR*XLEN-1:0] rd_data_o,
    output logic [NR-1:0]      rd_busy_o,
    input  logic [NW-1:0]      wb_en_i,
    input  logic [NW*AW-1:0]   wb_addr_i,
    input  logic [NW*XLEN-1:0] wb_data_i,
    input  logic               iss_valid_i,
    input  logic [AW-1:0]      iss_rd_i,
    output logic               iss_ready_o
);

    logic [XLEN-1:0]          regs_q [NREG];
    logic [XLEN-1:0]          regs_d [NREG];
    logic [NREG-1:0]          busy;
    logic [MAX_NW-1:0]        wb_en_pad;
    logic [MAX_NW*MAX_AW-1:0] wb_addr_pad;
    logic                     iss_fire;

    function automatic logic [XLEN-1:0] pick_wb(input logic [PW-1:0] port);
        logic [XLEN-1:0] v;
        v = '0;
        for (int w = 0; w < int'(NW); w++) begin
            if (port == PW'(w)) begin
                v = wb_data_i[w*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    always_comb begin
        wb_en_pad   = '0;
        wb_addr_pad = '0;
        for (int w = 0; w < int'(NW); w++) begin
            wb_en_pad[w]                 = wb_en_i[w];
            wb_addr_pad[w*MAX_AW +: AW]  = wb_addr_i[w*AW +: AW];
        end
    end

    // Write path: each register takes the highest-index port that targets it.
    always_comb begin
        wb_match_t m;
        for (int r = 0; r < int'(NREG); r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int r = 1; r < int'(NREG); r++) begin
            m = wb_match(MAX_AW'(r), wb_en_pad, wb_addr_pad);
            if (m.hit) begin
                regs_d[r] = pick_wb(m.port);
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < int'(NREG); r++) begin
            if (rst) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Ready looks at registered busy only, so a same-cycle writeback cannot unblock it.
    assign iss_ready_o = !rst && ((iss_rd_i == '0) || !busy[iss_rd_i]);
    assign iss_fire    = iss_valid_i && iss_ready_o;

    ysyx_22050550_rf_scoreboard #(
        .NREG (NREG),
        .NW   (NW),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (iss_fire),
        .set_rd_i   (iss_rd_i),
        .clr_en_i   (wb_en_i),
        .clr_addr_i (wb_addr_i),
        .busy_o     (busy)
    );

    always_comb begin
        logic [AW-1:0] a;
`ifdef YSYX_22050550_RF_BYPASS_EN
        logic [MAX_AW-1:0] a_pad;
        wb_match_t         m;
`endif
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < int'(NR); p++) begin
            a = rd_addr_i[p*AW +: AW];
`ifdef YSYX_22050550_RF_BYPASS_EN
            a_pad           = '0;
            a_pad[AW-1:0]   = a;
            m               = wb_match(a_pad, wb_en_pad, wb_addr_pad);
            if (!rst && (a != '0)) begin
                if (m.hit) begin
                    // Write-through: the in-flight result is already the architectural value.
                    rd_data_o[p*XLEN +: XLEN] = pick_wb(m.port);
                    rd_busy_o[p]              = 1'b0;
                end else begin
                    rd_data_o[p*XLEN +: XLEN] = regs_q[a];
                    rd_busy_o[p]              = busy[a];
                end
            end
`else
            if (!rst && (a != '0)) begin
                rd_data_o[p*XLEN +: XLEN] = regs_q[a];
                rd_busy_o[p]              = busy[a];
            end
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_regfile_sb.sv
module tb_ysyx_22050550_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR*AW-1:0]   rd_addr = '0;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wb_en = '0;
    logic [NW*AW-1:0]   wb_addr = '0;
    logic [NW*XLEN-1:0] wb_data = '0;
    logic               iss_valid = 1'b0;
    logic [AW-1:0]      iss_rd = '0;
    logic               iss_ready;

    ysyx_22050550_regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NR   (NR),
        .NW   (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and pending-result flags.
    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_busy [NREG];

    typedef struct packed {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d0;
        logic [1:0]      b;
        logic            rdy;
        logic [31:0]     cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    function automatic logic model_ready();
        return !rst && ((iss_rd == 0) || !m_busy[iss_rd]);
    endfunction

    function automatic logic [XLEN:0] model_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        logic            b;
        if (rst || a == 0) return '0;
        d = m_reg[a];
        b = m_busy[a];
`ifdef YSYX_22050550_RF_BYPASS_EN
        for (int w = 0; w < NW; w++) begin
            if (wb_en[w] && wb_addr[w*AW +: AW] == a) begin
                d = wb_data[w*XLEN +: XLEN];
                b = 1'b0;
            end
        end
`endif
        return {b, d};
    endfunction

    // Applies the inputs currently held on the bus as one clock edge.
    task automatic model_edge();
        logic rdy;
        rdy = model_ready();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wb_en[w] && wb_addr[w*AW +: AW] != 0) begin
                    m_reg[wb_addr[w*AW +: AW]]  = wb_data[w*XLEN +: XLEN];
                    m_busy[wb_addr[w*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic [1:0] en, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [XLEN-1:0] wd0, input logic [XLEN-1:0] wd1,
                        input logic iv, input logic [AW-1:0] ir);
        exp_t          e;
        logic [XLEN:0] r0;
        logic [XLEN:0] r1;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        rst       = r;
        rd_addr   = {ra1, ra0};
        wb_en     = en;
        wb_addr   = {wa1, wa0};
        wb_data   = {wd1, wd0};
        iss_valid = iv;
        iss_rd    = ir;
        r0 = model_read(ra0);
        r1 = model_read(ra1);
        e.d0  = r0[XLEN-1:0];
        e.d1  = r1[XLEN-1:0];
        e.b   = {r1[XLEN], r0[XLEN]};
        e.rdy = model_ready();
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] c,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, want);
    endtask

    // Monitor: outputs are stable by mid-cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data0",  e.cyc, rd_data[XLEN-1:0],    e.d0);
                chk("rd_data1",  e.cyc, rd_data[2*XLEN-1:XLEN], e.d1);
                chk("rd_busy",   e.cyc, XLEN'(rd_busy),       XLEN'(e.b));
                chk("iss_ready", e.cyc, XLEN'(iss_ready),     XLEN'(e.rdy));
            end
        end
    end

    initial begin
        logic [AW-1:0] a [6];
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        // Reset, then reset clears written state and blocks issue.
        step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 5, 3, 2'b00, 0, 0, 0, 0, 1, 2);
        step(0, 5, 0, 2'b01, 5, 0, 64'hDEAD, 0, 0, 0);
        step(0, 5, 5, 2'b00, 0, 0, 0, 0, 1, 6);
        step(1, 5, 6, 2'b00, 0, 0, 0, 0, 1, 5);
        step(0, 5, 6, 2'b00, 0, 0, 0, 0, 0, 0);
        // x0 immutable and issue to x0 fires without side effects.
        step(0, 0, 0, 2'b01, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        // Write priority: higher port wins.
        step(0, 7, 0, 2'b11, 7, 7, 64'h11, 64'h22, 0, 0);
        step(0, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        // Scoreboard and WAW stall.
        step(0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        step(0, 3, 3, 2'b00, 0, 0, 0, 0, 1, 3);
        step(0, 3, 0, 2'b01, 3, 0, 64'h5A, 0, 1, 3);
        step(0, 3, 3, 2'b00, 0, 0, 0, 0, 1, 3);
        step(0, 3, 0, 2'b10, 0, 3, 0, 64'h5B, 0, 0);
        // Set beats clear on the same register.
        step(0, 4, 0, 2'b01, 4, 0, 64'h9, 0, 1, 4);
        step(0, 4, 4, 2'b00, 0, 0, 0, 0, 1, 4);
        step(0, 4, 0, 2'b01, 4, 0, 64'h9, 0, 0, 0);
        // Bypass window on both read ports.
        step(0, 9, 9, 2'b10, 0, 9, 0, 64'hABC, 0, 0);
        step(0, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        // Random traffic concentrated on a few registers to force collisions.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 6; k++) begin
                a[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG-1))
                                                  : AW'($urandom_range(0, 7));
            end
            step(($urandom_range(0, 199) == 0), a[0], a[1], 2'($urandom),
                 a[2], a[3], {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), a[4]);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
